// File: rtl/led_scan_driver.sv
// led_scan_driver: multiplexed 7-segment scan driver with shadow/active data registers.
// Ports: clk, reset (sync, active-high); load strobes din (4 bits per digit) and blank
// (1 bit per digit) into the shadow register; an = one-hot digit enables, seg = a..g
// (both inverted when ACTIVE_LOW); dig_sel = index of the current digit slot.
module led_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_CNT = 50000,
    parameter int DEAD        = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*DIGITS-1:0]       din,
    input  logic [DIGITS-1:0]         blank,
    output logic [DIGITS-1:0]         an,
    output logic [6:0]                seg,
    output logic [$clog2(DIGITS)-1:0] dig_sel
);
    localparam int CW = $clog2(REFRESH_CNT);
    localparam int IW = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW != 0}};
    localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW != 0}};
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_din_q, sh_din_d, act_din_q, act_din_d;
    logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                boundary, lit;
    logic [3:0]          nib;

    always_comb begin
        boundary    = cnt_q == CW'(REFRESH_CNT - 1);
        cnt_d       = boundary ? '0 : cnt_q + 1'b1;
        idx_d       = boundary ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
        sh_din_d    = load ? din : sh_din_q;
        sh_blank_d  = load ? blank : sh_blank_q;
        // the shadow's next value already carries a coincident load, giving the bypass
        act_din_d   = boundary ? sh_din_d : act_din_q;
        act_blank_d = boundary ? sh_blank_d : act_blank_q;
        nib         = act_din_q[{idx_q, 2'b00} +: 4];
        lit         = cnt_q >= CW'(DEAD) && !act_blank_q[idx_q];
        an_d        = (lit ? DIGITS'(1) << idx_q : '0) ^ AN_OFF;
        seg_d       = (lit ? SEG_LUT[nib] : 7'b0) ^ SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_din_q    <= '0;
            sh_blank_q  <= '1;
            act_din_q   <= '0;
            act_blank_q <= '1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_din_q    <= sh_din_d;
            sh_blank_q  <= sh_blank_d;
            act_din_q   <= act_din_d;
            act_blank_q <= act_blank_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dig_sel = idx_q;
endmodule
